// File: rtl/result_uart_tx_if.sv
// Interface between the result monitor and its host side: the watched value,
// the capture enable, the UART line and the status outputs.
interface result_uart_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] reg_return;
  logic              capture_en;
  logic              tx_out;
  logic              busy;
  logic              fifo_full;
  logic [7:0]        drop_count;

  modport master (
    output reg_return, capture_en,
    input  tx_out, busy, fifo_full, drop_count
  );

  modport slave (
    input  reg_return, capture_en,
    output tx_out, busy, fifo_full, drop_count
  );
endinterface

// File: rtl/result_uart_tx.sv
// Captures each new distinct return value into a small FIFO and sends it MSB byte
// first over UART 8N1. Define RESULT_UART_TX_PARITY_EN for an even parity bit (8E1).
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  result_uart_tx_if.slave   bus
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_fifo_full;
  logic [DATA_W-1:0] r_last_value;
  logic [7:0]        r_drop_count;

  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [BYTE_W-1:0] r_byte_idx;
  logic [DATA_W-1:0] r_word;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_busy;
`ifdef RESULT_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic              w_change, w_push, w_pop, w_empty, w_baud_done;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_head;
  logic [7:0]        w_load_byte;

  assign w_empty     = (r_count == '0);
  assign w_change    = bus.capture_en && (bus.reg_return != r_last_value);
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = w_change && (!r_fifo_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_load_byte = (r_state == S_IDLE) ? w_head[DATA_W-1 -: 8] : r_word[DATA_W-1 -: 8];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: storage is not reset; pointers and occupancy alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.reg_return;
  end

  // NOTE: reset is synchronous, so rst is only tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fifo_full  <= 1'b0;
      r_last_value <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_change) r_last_value <= bus.reg_return;
      if (w_push)   r_wr_ptr     <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr     <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_fifo_full <= (w_count_next == DEPTH_C);
      if (w_change && !w_push && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 1'b1;
    end
  end

  // tx_out is registered: each transition loads the line level of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_baud <= w_baud_done ? '0 : r_baud + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_word     <= w_head << 8;
            r_shift    <= w_load_byte;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_state    <= S_START;
`ifdef RESULT_UART_TX_PARITY_EN
            r_parity   <= ^w_load_byte;
`endif
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            if (r_bit_idx == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef RESULT_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            if (r_byte_idx != LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_shift    <= w_load_byte;
              r_word     <= r_word << 8;
              r_tx       <= 1'b0;
              r_state    <= S_START;
`ifdef RESULT_UART_TX_PARITY_EN
              r_parity   <= ^w_load_byte;
`endif
            end else begin
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_out     = r_tx;
  assign bus.busy       = r_busy;
  assign bus.fifo_full  = r_fifo_full;
  assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: expected words are queued when driven and
// compared against words decoded from tx_out by a UART receiver model.
`timescale 1ns/1ps
module tb_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYCLES = (DW / 8) * FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_uart_tx_if #(.DATA_W(DW)) bus ();

  result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_W      (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          rst_epoch = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // UART receiver: samples each bit mid-period on the falling clock edge.
  initial begin : rx_model
    logic        prev;
    logic        st, sp;
    logic [7:0]  b;
    logic [31:0] word;
    int          nbytes, ep, last_ep;
`ifdef RESULT_UART_TX_PARITY_EN
    logic        par;
`endif
    prev = 1'b1; nbytes = 0; word = '0; last_ep = 0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && bus.tx_out === 1'b0 && rst === 1'b1) begin
        if (rst_epoch != last_ep) nbytes = 0;
        last_ep = rst_epoch;
        ep = rst_epoch;
        repeat (CPB / 2) @(negedge clk);
        st = bus.tx_out;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx_out;
        end
`ifdef RESULT_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = bus.tx_out;
`endif
        repeat (CPB) @(negedge clk);
        sp = bus.tx_out;
        if (ep != rst_epoch) begin
          nbytes = 0;
        end else begin
          check("start_bit", {31'd0, st}, 32'd0);
          check("stop_bit", {31'd0, sp}, 32'd1);
`ifdef RESULT_UART_TX_PARITY_EN
          check("parity_bit", {31'd0, par}, {31'd0, ^b});
`endif
          word = {word[23:0], b};
          nbytes++;
          if (nbytes == 4) begin
            nbytes = 0;
            check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) check("rx_word", word, sb_q.pop_front());
          end
        end
      end
      prev = bus.tx_out;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.reg_return = '0;
    rst_epoch++;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send(input logic [31:0] v);
    @(negedge clk);
    bus.reg_return = v;
    sb_q.push_back(v);
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (!bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int k = 0;
    while ((sb_q.size() != 0 || bus.busy) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, sb_q.size(), 32'd0);
  endtask

  task automatic count_quiet(input string tag, input int cycles);
    int low = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) low++;
    end
    check(tag, low, 32'd0);
  endtask

  initial begin : stim
    int cnt;
    rst = 1'b0;
    bus.reg_return = '0;
    bus.capture_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, bus.tx_out}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_full", {31'd0, bus.fifo_full}, 32'd0);
    check("rst_drop", {24'd0, bus.drop_count}, 32'd0);
    rst = 1'b1;
    bus.capture_en = 1'b1;

    // single word, busy length
    send(32'h0000_00A5);
    wait_busy("t1_busy_rise");
    cnt = 0;
    while (bus.busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("t1_busy_len", cnt, WORD_CYCLES);
    wait_drain("t1_drain", 200);

    // held value goes out once only
    send(32'h1234_5678);
    repeat (500) @(negedge clk);
    wait_drain("t2_drain", 400);
    check("t2_drop", {24'd0, bus.drop_count}, 32'd0);

    // parity-sensitive byte pattern
    send(32'h0000_0007);
    wait_drain("t6_drain", 400);

    // reset with a zero input: nothing is sent
    apply_reset();
    count_quiet("t3_quiet", 200);
    check("t3_drop", {24'd0, bus.drop_count}, 32'd0);

    // gated capture, then re-enable against the stale last value
    bus.capture_en = 1'b0;
    @(negedge clk);
    bus.reg_return = 32'hDEAD_0001;
    count_quiet("gate_quiet", 50);
    bus.capture_en = 1'b1;
    sb_q.push_back(32'hDEAD_0001);
    wait_drain("gate_drain", 400);

    // overflow while busy: two queued, three dropped
    apply_reset();
    send(32'h1111_1111);
    wait_busy("t4_busy_rise");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.reg_return = 32'h2000_0000 + i;
      if (i < 2) sb_q.push_back(32'h2000_0000 + i);
    end
    @(negedge clk);
    check("t4_full", {31'd0, bus.fifo_full}, 32'd1);
    check("t4_drop", {24'd0, bus.drop_count}, 32'd3);
    wait_drain("t4_drain", 3 * WORD_CYCLES + 200);
    check("t4_full_after", {31'd0, bus.fifo_full}, 32'd0);
    check("t4_drop_hold", {24'd0, bus.drop_count}, 32'd3);

    // reset mid-DATA of byte 2 with a second word queued
    apply_reset();
    send(32'hCAFE_BABE);
    wait_busy("t5_busy_rise");
    @(negedge clk);
    bus.reg_return = 32'h0BAD_F00D;
    repeat (2 * FRAME_BITS * CPB + CPB + 14) @(negedge clk);
    rst = 1'b0;
    bus.reg_return = '0;
    rst_epoch++;
    sb_q.delete();
    @(negedge clk);
    check("t5_tx", {31'd0, bus.tx_out}, 32'd1);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_full", {31'd0, bus.fifo_full}, 32'd0);
    check("t5_drop", {24'd0, bus.drop_count}, 32'd0);
    rst = 1'b1;
    count_quiet("t5_quiet", 300);

    check("final_sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the processor top's `Register_return` output.
- Watches the 32-bit return value every cycle and queues each new distinct value in a small FIFO.
- Serialises queued words over a UART TX line (8N1, 4 bytes per word, MSB byte first) so program results reach a host without a debugger.
- Lives in the board-level wrapper beside the processor, on the same clock.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 2.
- FIFO_DEPTH, 8, word entries in capture FIFO; power of two, minimum 2.
- DATA_W, 32, width of monitored value; must be a multiple of 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- reg_return  input  DATA_W  value to monitor (processor return register).
- capture_en  input  1  1 = change detection armed; 0 = no new captures (queued words still drain).
- tx_out  output  1  UART serial line, idles high.
- busy  output  1  1 while a word is being shifted out.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- drop_count  output  8  captures lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (rst=0 sampled at a clock edge):
  - tx_out=1, busy=0, fifo_full=0, drop_count=0.
  - FIFO emptied; last_value register cleared to 0.
  - TX FSM returns to IDLE. Any word in flight is abandoned; the partial frame is not resumed.
- Change capture, every cycle with rst=1:
  - change = capture_en && (reg_return != last_value).
  - On change: last_value <= reg_return, regardless of whether the push succeeds.
  - Push succeeds when FIFO not full, or when full and a pop occurs the same cycle.
  - Push refused: drop_count increments, saturating at 255.
  - While capture_en=0, last_value holds. Re-enabling compares against the stale value.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter 0..FIFO_DEPTH; fifo_full is registered from occupancy.
  - Write-to-read latency: a word pushed in cycle N can be popped in cycle N+1 at the earliest.
- TX FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: tx_out=1. If FIFO non-empty: pop the head into a DATA_W shift word, byte_idx=0, load the top byte into the bit shifter, busy=1, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles.
    - If byte_idx < DATA_W/8-1: increment byte_idx, load the next lower byte, go to START.
    - Otherwise: busy=0, go to IDLE.
  - Word timing: DATA_W/8 * 10 * CLKS_PER_BIT cycles. Back-to-back words have one IDLE cycle between frames.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Cleared on every state entry.
  - State advances when it reaches CLKS_PER_BIT-1.
- Outputs: tx_out and busy are registered, with no combinational path from reg_return.

Optional Feature:
- Macro: RESULT_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits per byte.
- Undefined:
  - No PARITY state or logic; 8N1 framing exactly as above.

Test Plan:
1. CLKS_PER_BIT=4, reset, then reg_return=0x0000_00A5 with capture_en=1 -> one word sent.
   - Bytes 0x00,0x00,0x00,0xA5.
   - Last byte on tx_out: 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop).
   - busy high for exactly 160 cycles.
2. reg_return held at 0x1234_5678 for 500 cycles -> exactly one word transmitted; no repeat.
3. Reset to 0 then reg_return stays 0 -> nothing sent; tx_out stays 1, drop_count=0.
4. FIFO_DEPTH=2, TX busy, 5 distinct values on consecutive cycles:
   - After 2 enqueue, fifo_full=1 and drop_count=3.
   - Only the first in-flight word plus the 2 queued words appear on the line.
5. rst=0 asserted mid-DATA of byte 2 -> next edge: tx_out=1, busy=0, FIFO empty; no further line activity.
6. With RESULT_UART_TX_PARITY_EN, value 0x0000_0007 -> last byte parity bit=1, frame 11 bits, word 176 cycles at CLKS_PER_BIT=4.
